auth_xfer_scheduler: RTL and testbench
======================================

Name: auth_xfer_scheduler

Overview:
- Sequences USB Type-C authentication request/response exchanges between on-chip requesters and the USB host link.
- Round-robin arbitrates up to N requesters and builds the 16-bit message header.
- Drives the request/acknowledge/response handshake toward the host, validates the response header, and returns a completion status to the granted requester.
- Sits between the authentication engines and the host-facing message port.

Parameters:
- N_REQ, 3, number of requesters (1..8).
- PROTO_VER, 8'h01, ProtocolVersion byte inserted in every header.
- ACK_TIMEOUT, 16'd1000, max cycles from resp_req_out to ack_out_resp.
- RESP_TIMEOUT, 16'd4000, max cycles from ack to response valid.
- MAX_RETRY, 2, retries per transfer (used only with AUTH_RETRY_EN).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester transfer request; level, held until done.
- req_type  input  8*N_REQ  MessageType byte per requester; slice i = bits [8i+7:8i].
- grant  output  N_REQ  one-hot grant, held for the whole transfer.
- done  output  1  one-cycle pulse when the granted transfer finishes.
- status  output  2  result code, valid with done: 00 OK, 01 host ERROR, 10 mismatch, 11 timeout.
- resp_req_out  output  1  request to host; high from SEND until ack.
- auth_hdr_out  output  16  {PROTO_VER, req_type of granted requester}.
- ack_out_resp  input  1  host acknowledge of the request.
- resp_valid  input  1  host response header valid, one-cycle pulse.
- resp_hdr_in  input  16  host response {version, type}.

Behaviour:
- Reset values: grant 0, done 0, status 00, resp_req_out 0, auth_hdr_out 16'h0000.
- Internal state on reset: FSM IDLE, rr pointer 0, counters 0.
- IDLE:
  - If any req is high: go to ARB next cycle.
  - Otherwise: stay in IDLE.
- ARB (1 cycle):
  - Pick the first asserted req starting at rr pointer and wrapping modulo N_REQ.
  - Assert grant; latch auth_hdr_out.
  - Set rr pointer = winner+1, wrapping N_REQ-1 -> 0.
  - Go to SEND.
- SEND:
  - Assert resp_req_out; clear timer; go to WAIT_ACK.
- WAIT_ACK:
  - resp_req_out stays high.
  - On ack_out_resp: drop resp_req_out next cycle, clear timer, go to WAIT_RESP.
  - If timer reaches ACK_TIMEOUT: go to FIN with status 11.
- WAIT_RESP:
  - On resp_valid, classify the response:
    - version != PROTO_VER, or type != (req_type & 8'h7F): status 10.
    - Exception: type 8'h7F -> status 01.
    - Otherwise: status 00.
  - If timer reaches RESP_TIMEOUT: status 11.
  - Any outcome goes to FIN.
  - Example: request 8'h81 expects response 8'h01.
- FIN:
  - Pulse done one cycle; drop grant the same cycle; go to IDLE.
  - Next arbitration occurs no earlier than 2 cycles after done.
- Timer: 16-bit saturating, increments each cycle in the WAIT_* states.
- Simultaneous events:
  - ack_out_resp and timeout in the same cycle: ack wins.
  - resp_valid and timeout in the same cycle: response wins.
  - resp_valid in WAIT_ACK: ignored.
  - ack_out_resp outside WAIT_ACK: ignored.
- Requester drops req mid-transfer: transfer completes normally; done still pulses.
- reset mid-operation: all outputs return to reset values immediately (async); a pending host exchange is abandoned.
- Latency: req -> resp_req_out = 3 cycles (IDLE->ARB->SEND, registered).

Optional Feature:
- Macro AUTH_RETRY_EN.
- Defined:
  - On status 11 or 10, with retry count < MAX_RETRY: increment count and return to SEND; grant is held; done is not pulsed.
  - Status 01 is never retried.
  - Retry count clears in ARB.
- Undefined: no retry logic; every outcome goes directly to FIN. MAX_RETRY is unused.

Test Plan:
- Single request:
  - Stimulus: req=3'b001, req_type[7:0]=8'h81; ack 5 cycles later; resp_valid with 16'h0101.
  - Response: auth_hdr_out=16'h0181, grant=001, done pulse, status 00, resp_req_out low after ack.
- Round-robin:
  - Stimulus: req=3'b111 held for three transfers.
  - Response: grants in order 001, 010, 100, then 001; one done per grant.
- Host error:
  - Stimulus: req_type 8'h83; response 16'h017F.
  - Response: status 01, no retry even with AUTH_RETRY_EN.
- Mismatch:
  - Stimulus: req_type 8'h82; response 16'h0103.
  - Response without AUTH_RETRY_EN: status 10.
  - Response with AUTH_RETRY_EN, MAX_RETRY=2: two resends, then status 10.
- Timeouts:
  - No ack for ACK_TIMEOUT cycles -> status 11, resp_req_out drops.
  - ack given, then resp_valid and timeout coincide -> response status reported.
- Reset mid-transfer:
  - Stimulus: assert reset during WAIT_RESP.
  - Response: grant, resp_req_out, auth_hdr_out zero asynchronously; after release with req still high, arbitration restarts from requester 0.

Source files
------------

// File: rtl/auth_xfer_scheduler_if.sv
// Requester-side and host-side signal bundle of auth_xfer_scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface auth_xfer_scheduler_if #(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_type;
   logic [N_REQ-1:0]   grant;
   logic               done;
   logic [1:0]         status;
   logic               resp_req_out;
   logic [15:0]        auth_hdr_out;
   logic               ack_out_resp;
   logic               resp_valid;
   logic [15:0]        resp_hdr_in;

   modport master (
      input  req, req_type, ack_out_resp, resp_valid, resp_hdr_in,
      output grant, done, status, resp_req_out, auth_hdr_out
   );

   modport slave (
      output req, req_type, ack_out_resp, resp_valid, resp_hdr_in,
      input  grant, done, status, resp_req_out, auth_hdr_out
   );
endinterface

// File: rtl/auth_xfer_scheduler.sv
// Round-robin scheduler for USB Type-C authentication request/response exchanges.
// Define AUTH_RETRY_EN to resend mismatched or timed-out exchanges up to MAX_RETRY times.
module auth_xfer_scheduler #(
   parameter int          N_REQ        = 3,
   parameter logic [7:0]  PROTO_VER    = 8'h01,
   parameter logic [15:0] ACK_TIMEOUT  = 16'd1000,
   parameter logic [15:0] RESP_TIMEOUT = 16'd4000,
   parameter int          MAX_RETRY    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   auth_xfer_scheduler_if.master bus
);

   typedef enum logic [2:0] {IDLE, ARB, SEND, WAIT_ACK, WAIT_RESP, FIN} state_t;

   localparam logic [3:0] LAST_IDX = 4'(N_REQ - 1);

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d, arb_onehot;
   logic             done_q, done_d;
   logic [1:0]       status_q, status_d;
   logic             resp_req_q, resp_req_d;
   logic [15:0]      hdr_q, hdr_d;
   logic [15:0]      timer_q, timer_d, timer_inc;
   logic [3:0]       rr_q, rr_d;
   logic [3:0]       win_idx, win_hi, win_lo;
   logic             found_hi;
   logic [7:0]       win_type;
   logic             outcome_vld;
   logic [1:0]       outcome;
   logic             retry_now;
`ifdef AUTH_RETRY_EN
   logic [3:0]       retry_q, retry_d;
`endif

   // Type 7F is the host's error report and overrides any version/type mismatch.
   function automatic logic [1:0] classify(input logic [15:0] rsp, input logic [7:0] rtype);
      if (rsp[7:0] == 8'h7F)
         return 2'b01;
      else if ((rsp[15:8] != PROTO_VER) || (rsp[7:0] != (rtype & 8'h7F)))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   // Lowest requester at or above the pointer wins, else lowest overall (wrap).
   always_comb begin
      win_hi   = '0;
      win_lo   = '0;
      found_hi = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            win_lo = 4'(i);
            if (4'(i) >= rr_q) begin
               win_hi   = 4'(i);
               found_hi = 1'b1;
            end
         end
      end
      win_idx    = found_hi ? win_hi : win_lo;
      arb_onehot = '0;
      win_type   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (4'(i) == win_idx) begin
            arb_onehot[i] = 1'b1;
            win_type      = bus.req_type[8*i +: 8];
         end
      end
   end

   assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

`ifdef AUTH_RETRY_EN
   assign retry_now = outcome_vld && outcome[1] && (retry_q < 4'(MAX_RETRY));
`else
   assign retry_now = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      done_d      = 1'b0;
      status_d    = status_q;
      resp_req_d  = resp_req_q;
      hdr_d       = hdr_q;
      timer_d     = timer_q;
      rr_d        = rr_q;
      outcome_vld = 1'b0;
      outcome     = 2'b00;
`ifdef AUTH_RETRY_EN
      retry_d     = retry_q;
`endif
      case (state_q)
         IDLE: if (|bus.req) state_d = ARB;
         ARB: begin
            if (|bus.req) begin
               grant_d = arb_onehot;
               hdr_d   = {PROTO_VER, win_type};
               rr_d    = (win_idx == LAST_IDX) ? 4'd0 : win_idx + 4'd1;
               state_d = SEND;
`ifdef AUTH_RETRY_EN
               retry_d = 4'd0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            resp_req_d = 1'b1;
            timer_d    = 16'd0;
            state_d    = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (bus.ack_out_resp) begin
               resp_req_d = 1'b0;
               timer_d    = 16'd0;
               state_d    = WAIT_RESP;
            end else if (timer_q >= ACK_TIMEOUT) begin
               outcome_vld = 1'b1;
               outcome     = 2'b11;
            end else begin
               timer_d = timer_inc;
            end
         end
         WAIT_RESP: begin
            if (bus.resp_valid) begin
               outcome_vld = 1'b1;
               outcome     = classify(bus.resp_hdr_in, hdr_q[7:0]);
            end else if (timer_q >= RESP_TIMEOUT) begin
               outcome_vld = 1'b1;
               outcome     = 2'b11;
            end else begin
               timer_d = timer_inc;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (outcome_vld) begin
         resp_req_d = 1'b0;
         if (retry_now) begin
            state_d = SEND;
`ifdef AUTH_RETRY_EN
            retry_d = retry_q + 4'd1;
`endif
         end else begin
            status_d = outcome;
            done_d   = 1'b1;
            grant_d  = '0;
            state_d  = FIN;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         done_q     <= 1'b0;
         status_q   <= 2'b00;
         resp_req_q <= 1'b0;
         hdr_q      <= 16'h0000;
         timer_q    <= 16'd0;
         rr_q       <= 4'd0;
`ifdef AUTH_RETRY_EN
         retry_q    <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         status_q   <= status_d;
         resp_req_q <= resp_req_d;
         hdr_q      <= hdr_d;
         timer_q    <= timer_d;
         rr_q       <= rr_d;
`ifdef AUTH_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   assign bus.grant        = grant_q;
   assign bus.done         = done_q;
   assign bus.status       = status_q;
   assign bus.resp_req_out = resp_req_q;
   assign bus.auth_hdr_out = hdr_q;

endmodule

// File: tb/tb_auth_xfer_scheduler.sv
// Directed self-checking bench for auth_xfer_scheduler (N_REQ=3, default timeouts).
module tb_auth_xfer_scheduler;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   auth_xfer_scheduler_if #(.N_REQ(3)) bus();

   auth_xfer_scheduler #(
      .N_REQ(3), .PROTO_VER(8'h01), .ACK_TIMEOUT(16'd1000),
      .RESP_TIMEOUT(16'd4000), .MAX_RETRY(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial begin
      #600000;
      $display("FAIL watchdog simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Serves every host request with ack then the given response until done is seen.
   task automatic run_xfer(input logic [15:0] rsp, output logic [2:0] g, output logic [15:0] hdr,
                           output logic [1:0] st, output int n_ex, output logic ok,
                           output logic [2:0] g_fin);
      ok = 1'b0; n_ex = 0; g = '0; hdr = '0; st = '0; g_fin = '1;
      for (int c = 0; c < 300 && !ok; c++) begin
         if (bus.done) begin
            ok = 1'b1; st = bus.status; g_fin = bus.grant;
            tick(1);
         end else if (bus.resp_req_out) begin
            n_ex++; g = bus.grant; hdr = bus.auth_hdr_out;
            bus.ack_out_resp = 1'b1; tick(1); bus.ack_out_resp = 1'b0;
            bus.resp_valid = 1'b1; bus.resp_hdr_in = rsp; tick(1); bus.resp_valid = 1'b0;
         end else begin
            tick(1);
         end
      end
   endtask

   task automatic test_reset();
      bus.req = '0; bus.req_type = '0; bus.ack_out_resp = 1'b0;
      bus.resp_valid = 1'b0; bus.resp_hdr_in = '0;
      reset = 1'b1;
      tick(2);
      checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", bus.grant); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.status !== 2'b00) begin failures++; $display("FAIL reset_status got=%b exp=00", bus.status); end
      checks++; if (bus.resp_req_out !== 1'b0) begin failures++; $display("FAIL reset_resp_req got=%b exp=0", bus.resp_req_out); end
      checks++; if (bus.auth_hdr_out !== 16'h0000) begin failures++; $display("FAIL reset_hdr got=%h exp=0000", bus.auth_hdr_out); end
      reset = 1'b0;
      tick(2);
      checks++; if (bus.resp_req_out !== 1'b0 || bus.grant !== 3'b000) begin failures++; $display("FAIL idle_no_req got=%b/%b exp=0/000", bus.resp_req_out, bus.grant); end
   endtask

   task automatic test_single();
      bus.req_type = 24'h000081; bus.req = 3'b001;
      tick(1);
      checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL single_arb_grant got=%b exp=000", bus.grant); end
      tick(1);
      checks++; if (bus.grant !== 3'b001) begin failures++; $display("FAIL single_grant got=%b exp=001", bus.grant); end
      checks++; if (bus.auth_hdr_out !== 16'h0181) begin failures++; $display("FAIL single_hdr got=%h exp=0181", bus.auth_hdr_out); end
      checks++; if (bus.resp_req_out !== 1'b0) begin failures++; $display("FAIL single_req_early got=%b exp=0", bus.resp_req_out); end
      tick(1);
      checks++; if (bus.resp_req_out !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", bus.resp_req_out); end
      bus.resp_valid = 1'b1; bus.resp_hdr_in = 16'h0101; tick(1); bus.resp_valid = 1'b0;
      checks++; if (bus.done !== 1'b0 || bus.resp_req_out !== 1'b1) begin failures++; $display("FAIL resp_in_wait_ack got=done%b/req%b exp=done0/req1", bus.done, bus.resp_req_out); end
      tick(3);
      bus.ack_out_resp = 1'b1; tick(1); bus.ack_out_resp = 1'b0;
      checks++; if (bus.resp_req_out !== 1'b0) begin failures++; $display("FAIL single_req_after_ack got=%b exp=0", bus.resp_req_out); end
      checks++; if (bus.grant !== 3'b001) begin failures++; $display("FAIL single_grant_held got=%b exp=001", bus.grant); end
      bus.ack_out_resp = 1'b1; tick(1); bus.ack_out_resp = 1'b0; tick(1);
      checks++; if (bus.done !== 1'b0 || bus.resp_req_out !== 1'b0) begin failures++; $display("FAIL ack_in_wait_resp got=done%b/req%b exp=done0/req0", bus.done, bus.resp_req_out); end
      bus.resp_valid = 1'b1; bus.resp_hdr_in = 16'h0101; tick(1); bus.resp_valid = 1'b0;
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", bus.done); end
      checks++; if (bus.status !== 2'b00) begin failures++; $display("FAIL single_status got=%b exp=00", bus.status); end
      checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL single_grant_drop got=%b exp=000", bus.grant); end
      bus.req = 3'b000; tick(1);
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", bus.done); end
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
      logic [15:0] exp_h [4] = '{16'h0181, 16'h0182, 16'h0183, 16'h0181};
      logic [1:0]  exp_s [4] = '{2'b00, 2'b10, 2'b10, 2'b00};
      logic [2:0]  g, gf;
      logic [15:0] h;
      logic [1:0]  st;
      int          n;
      logic        ok;
      reset = 1'b1; tick(1); reset = 1'b0;
      bus.req_type = 24'h838281; bus.req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         run_xfer(16'h0101, g, h, st, n, ok, gf);
         checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_done[%0d] got=%b exp=1", k, ok); end
         checks++; if (g !== exp_g[k]) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, g, exp_g[k]); end
         checks++; if (h !== exp_h[k]) begin failures++; $display("FAIL rr_hdr[%0d] got=%h exp=%h", k, h, exp_h[k]); end
         checks++; if (st !== exp_s[k]) begin failures++; $display("FAIL rr_status[%0d] got=%b exp=%b", k, st, exp_s[k]); end
         checks++; if (gf !== 3'b000) begin failures++; $display("FAIL rr_grant_at_done[%0d] got=%b exp=000", k, gf); end
      end
      bus.req = 3'b000; tick(2);
   endtask

   task automatic test_host_error();
      logic [2:0]  g, gf;
      logic [15:0] h;
      logic [1:0]  st;
      int          n;
      logic        ok;
      bus.req_type = 24'h830000; bus.req = 3'b100;
      run_xfer(16'h017F, g, h, st, n, ok, gf);
      bus.req = 3'b000;
      checks++; if (ok !== 1'b1 || st !== 2'b01) begin failures++; $display("FAIL host_err_status got=ok%b/%b exp=ok1/01", ok, st); end
      checks++; if (n !== 1) begin failures++; $display("FAIL host_err_sends got=%0d exp=1", n); end
      checks++; if (g !== 3'b100 || h !== 16'h0183) begin failures++; $display("FAIL host_err_grant_hdr got=%b/%h exp=100/0183", g, h); end
      tick(2);
   endtask

   task automatic test_mismatch();
      logic [2:0]  g, gf;
      logic [15:0] h;
      logic [1:0]  st;
      int          n, exp_n;
      logic        ok;
`ifdef AUTH_RETRY_EN
      exp_n = 3;
`else
      exp_n = 1;
`endif
      bus.req_type = 24'h008200; bus.req = 3'b010;
      run_xfer(16'h0103, g, h, st, n, ok, gf);
      bus.req = 3'b000;
      checks++; if (ok !== 1'b1 || st !== 2'b10) begin failures++; $display("FAIL type_mismatch_status got=ok%b/%b exp=ok1/10", ok, st); end
      checks++; if (n !== exp_n) begin failures++; $display("FAIL type_mismatch_sends got=%0d exp=%0d", n, exp_n); end
      tick(2);
      bus.req_type = 24'h000081; bus.req = 3'b001;
      run_xfer(16'h0201, g, h, st, n, ok, gf);
      bus.req = 3'b000;
      checks++; if (ok !== 1'b1 || st !== 2'b10) begin failures++; $display("FAIL ver_mismatch_status got=ok%b/%b exp=ok1/10", ok, st); end
      tick(2);
      bus.req_type = 24'h008200; bus.req = 3'b010;
      run_xfer(16'h0102, g, h, st, n, ok, gf);
      bus.req = 3'b000;
      checks++; if (ok !== 1'b1 || st !== 2'b00) begin failures++; $display("FAIL masked_type_ok got=ok%b/%b exp=ok1/00", ok, st); end
      tick(2);
   endtask

   task automatic test_ack_timeout();
      int n;
      bus.req_type = 24'h000081; bus.req = 3'b001;
      for (int c = 0; c < 10 && !bus.resp_req_out; c++) tick(1);
      checks++; if (bus.resp_req_out !== 1'b1) begin failures++; $display("FAIL ack_to_req_raise got=%b exp=1", bus.resp_req_out); end
      n = 0;
      while (!bus.done && n < 1100) begin tick(1); n++; end
      checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL ack_to_done got=%b exp=1", bus.done); end
      checks++; if (bus.status !== 2'b11) begin failures++; $display("FAIL ack_to_status got=%b exp=11", bus.status); end
      checks++; if (bus.resp_req_out !== 1'b0) begin failures++; $display("FAIL ack_to_req_drop got=%b exp=0", bus.resp_req_out); end
      checks++; if (n < 1000 || n > 1002) begin failures++; $display("FAIL ack_to_cycles got=%0d exp=1000..1002", n); end
      bus.req = 3'b000; tick(2);
   endtask

   task automatic test_resp_coincide();
      bus.req_type = 24'h000081; bus.req = 3'b001;
      for (int c = 0; c < 10 && !bus.resp_req_out; c++) tick(1);
      bus.ack_out_resp = 1'b1; tick(1); bus.ack_out_resp = 1'b0;
      tick(4000);
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL resp_to_early got=%b exp=0", bus.done); end
      bus.resp_valid = 1'b1; bus.resp_hdr_in = 16'h0101; tick(1); bus.resp_valid = 1'b0;
      checks++; if (bus.done !== 1'b1 || bus.status !== 2'b00) begin failures++; $display("FAIL resp_wins_timeout got=done%b/%b exp=done1/00", bus.done, bus.status); end
      bus.req = 3'b000; tick(2);
   endtask

   task automatic test_reset_mid();
      logic [2:0]  g, gf;
      logic [15:0] h;
      logic [1:0]  st;
      int          n;
      logic        ok;
      bus.req_type = 24'h008281; bus.req = 3'b011;
      for (int c = 0; c < 10 && !bus.resp_req_out; c++) tick(1);
      checks++; if (bus.grant !== 3'b010) begin failures++; $display("FAIL mid_pre_grant got=%b exp=010", bus.grant); end
      bus.ack_out_resp = 1'b1; tick(1); bus.ack_out_resp = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL mid_async_grant got=%b exp=000", bus.grant); end
      checks++; if (bus.auth_hdr_out !== 16'h0000) begin failures++; $display("FAIL mid_async_hdr got=%h exp=0000", bus.auth_hdr_out); end
      checks++; if (bus.resp_req_out !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mid_async_ctrl got=req%b/done%b exp=req0/done0", bus.resp_req_out, bus.done); end
      @(negedge clk); reset = 1'b0;
      for (int c = 0; c < 10 && bus.grant == 3'b000; c++) tick(1);
      checks++; if (bus.grant !== 3'b001 || bus.auth_hdr_out !== 16'h0181) begin failures++; $display("FAIL mid_restart got=%b/%h exp=001/0181", bus.grant, bus.auth_hdr_out); end
      run_xfer(16'h0101, g, h, st, n, ok, gf);
      bus.req = 3'b000;
      checks++; if (ok !== 1'b1 || st !== 2'b00) begin failures++; $display("FAIL mid_resume got=ok%b/%b exp=ok1/00", ok, st); end
      tick(2);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_host_error();
      test_mismatch();
      test_ack_timeout();
      test_resp_coincide();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
